// File: rtl/det_pkg.sv
// det_pkg: shared types and default parameters for the pattern detector and its window monitor.
package det_pkg;
    typedef enum logic {IDLE, RUN} mon_state_t;
    localparam int DEF_WINDOW    = 16;
    localparam int DEF_CNT_W     = 8;
    localparam int DEF_THRESHOLD = 3;
endpackage

// File: rtl/detect_window_monitor.sv
// detect_window_monitor: counts detector hits per fixed window, reports them on a valid/ready port with sticky alarm/overrun.
module detect_window_monitor
    import det_pkg::*;
#(
    parameter int WINDOW    = DEF_WINDOW,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int THRESHOLD = DEF_THRESHOLD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             detected,
    input  logic             result_ready,
    input  logic             status_clr,
    output logic [CNT_W-1:0] result_data,
    output logic             result_valid,
    output logic             alarm,
    output logic             overrun
);
    localparam int WW = $clog2(WINDOW);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic b);
        return (b && &a) ? a : a + CNT_W'(b);
    endfunction

    mon_state_t       state_q, state_d;
    logic             det_q;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d, result_data_q, result_data_d, final_cnt;
    logic             result_valid_q, result_valid_d, alarm_q, alarm_d, overrun_q, overrun_d;
    logic             win_end, keep_run;

    always_comb begin
        win_end        = state_q == RUN && wcnt_q == WW'(WINDOW - 1);
        keep_run       = state_q == RUN && enable && !win_end;
        final_cnt      = sat_add(ecnt_q, det_q);
        state_d        = enable ? RUN : IDLE;
        wcnt_d         = keep_run ? wcnt_q + 1'b1 : '0;
        ecnt_d         = keep_run ? final_cnt : '0;
        result_data_d  = win_end ? final_cnt : result_data_q;
        result_valid_d = win_end || (result_valid_q && !result_ready);
        // Sets are ORed after the clear so a same-cycle window end beats status_clr.
        alarm_d        = (win_end && 32'(final_cnt) >= THRESHOLD) || (alarm_q && !status_clr);
        overrun_d      = (win_end && result_valid_q && !result_ready) || (overrun_q && !status_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            det_q          <= 1'b0;
            wcnt_q         <= '0;
            ecnt_q         <= '0;
            result_data_q  <= '0;
            result_valid_q <= 1'b0;
            alarm_q        <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            det_q          <= detected;
            wcnt_q         <= wcnt_d;
            ecnt_q         <= ecnt_d;
            result_data_q  <= result_data_d;
            result_valid_q <= result_valid_d;
            alarm_q        <= alarm_d;
            overrun_q      <= overrun_d;
        end
    end

    assign result_data  = result_data_q;
    assign result_valid = result_valid_q;
    assign alarm        = alarm_q;
    assign overrun      = overrun_q;
endmodule

// File: doc/detect_window_monitor.md
# detect_window_monitor

Downstream consumer of the serial pattern detector's one-bit `detected` flag. Counts the cycles in which `detected` is high over fixed windows of `WINDOW` clock cycles. At each window end it presents the count on a valid/ready result port and raises a sticky alarm when the count reaches `THRESHOLD`. It converts the detector's per-cycle strobe into rate information for control logic.

## Interface
- `WINDOW`, 16: window length in clock cycles; at least 2.
- `CNT_W`, 8: width of the event count and result.
- `THRESHOLD`, 3: alarm level; alarm is set when the window count is at least `THRESHOLD`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run request; windows are counted only while this is high.
- `detected`  in  1  detector flag; each high cycle counts as one event.
- `result_ready`  in  1  consumer accepts `result_data` when this and `result_valid` are both high.
- `status_clr`  in  1  one-cycle pulse that clears `alarm` and `overrun`.
- `result_data`  out  CNT_W  count for the last completed window.
- `result_valid`  out  1  `result_data` holds a result that has not yet been taken.
- `alarm`  out  1  sticky; a window count reached `THRESHOLD`.
- `overrun`  out  1  sticky; an unread result was overwritten.

## Operation
- **Input register.** `detected` is registered into `det_q` every cycle, regardless of state.
- **IDLE state.**
  - `wcnt` = 0 and `ecnt` = 0.
  - On `enable` = 1, go to RUN on the next edge. The first RUN cycle has `wcnt` = 0.
- **RUN state.**
  - `wcnt` increments each cycle from 0 to WINDOW-1, then wraps to 0.
  - `ecnt` adds `det_q` each cycle and saturates at 2^CNT_W - 1.
- **Window end** (the cycle where `wcnt` = WINDOW-1):
  - Final count = saturating `ecnt` + `det_q`.
  - Load the final count into `result_data` and set `result_valid`.
  - Clear `ecnt` to 0; the next window starts with no gap.
  - If final count ≥ THRESHOLD, set `alarm`.
- **Leaving RUN.** `enable` = 0 in RUN returns to IDLE on the next edge. The partial window is discarded and no result is produced. Any pending result and the status flags are kept.
- **Result handshake.** `result_valid` clears on the edge where `result_valid` and `result_ready` are both 1. `result_data` stays stable while `result_valid` is high, except when it is overwritten.
- **Simultaneous events:**
  - Window end in the same cycle as a completed handshake: the new result loads, `result_valid` stays 1, `overrun` is not set.
  - Window end while `result_valid` = 1 and `result_ready` = 0: the new result overwrites the old one and `overrun` is set.
  - `status_clr` in the same cycle as a window end that would set a flag: the set wins.
- **Reset** (asynchronous, any time, including mid-window):
  - State = IDLE; `det_q`, `wcnt`, `ecnt` = 0.
  - `result_data` = 0, `result_valid` = 0, `alarm` = 0, `overrun` = 0.

## Timing
- `detected` high at cycle t is in `det_q` at t+1 and is counted in the window that contains t+1.
- `result_valid` rises one edge after the window-end cycle. That edge lies WINDOW cycles after the first RUN cycle, and every WINDOW cycles after that.
- `alarm` and `overrun` update on the same edge as `result_valid`.
- `status_clr` takes effect on the next edge.
- All outputs are registered; there are no combinational paths from input to output.
- `enable` rising in IDLE: the first counted `det_q` sample is in the cycle after the IDLE→RUN edge.

## Structure
- Shared package `det_pkg`:
  - State enum `mon_state_t` with values IDLE and RUN.
  - Default `WINDOW`, `CNT_W` and `THRESHOLD` constants, shared with the detector's integration top.
- `wcnt` width is $clog2(WINDOW).
- Single module; no sub-module is needed. The saturating add is an inline function.

## Test plan
Parameters for all scenarios: WINDOW=16, CNT_W=8, THRESHOLD=3.

1. **Reset.** Assert `reset` mid-run → all outputs 0 immediately. `enable` held at 1 after release → first `result_valid` 17 edges after release.
2. **Below threshold.** `result_ready` = 1; 2 single-cycle `detected` pulses in one window → `result_data` = 2, `result_valid` high for 1 cycle, `alarm` = 0.
3. **Alarm.**
   - 3 pulses in one window → `alarm` = 1.
   - Next window has 0 pulses → `alarm` stays 1.
   - Pulse `status_clr` → `alarm` = 0.
   - `status_clr` on a window-end cycle with count 4 → `alarm` stays 1.
4. **Overrun.** `result_ready` = 0 across 2 windows with counts 1 then 5 → `result_data` = 5, `overrun` = 1. Assert `result_ready` → `result_valid` falls after 1 cycle.
5. **Saturation.**
   - `detected` held 1 for a full window → `result_data` = 16.
   - With CNT_W=4 → `result_data` = 15.
   - Window boundary: pulse on the last `det_q` cycle of a window → counted in that window, not the next.
6. **Enable drop.** Drop `enable` at `wcnt` = 9 with 2 events counted → no result. Re-enable → next result counts only new events.
